// File: rtl/ddr_port_arbiter_pkg.sv
// Shared types and helpers for the DDR port arbiter: FSM encoding,
// line-length limit and the beat-address mask helper.
package ddr_port_arbiter_pkg;

  // Longest supported line is 1<<MAX_BW words (16 beats)
  localparam int unsigned MAX_BW = 4;
  localparam int unsigned BEAT_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  // Byte-address bits that select a word inside a line of 1<<bw words
  function automatic logic [31:0] beat_mask(input logic [3:0] bw);
    beat_mask = ((32'd1 << bw) - 32'd1) << 2;
  endfunction

endpackage

// File: rtl/ddr_port_arbiter_arb_rr.sv
// Combinational round-robin picker: the search starts one past the
// previously granted port and wraps modulo NUM_PORTS.
module arb_rr #(
  parameter int NUM_PORTS = 2,
  parameter int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [PTR_W-1:0]     ptr_i,
  output logic [NUM_PORTS-1:0] gnt_oh_o,
  output logic [PTR_W-1:0]     gnt_bin_o,
  output logic                 gnt_vld_o
);

  // Rotating-priority search for the first requesting port after ptr_i
  always_comb begin
    int idx;
    idx       = 0;
    gnt_oh_o  = '0;
    gnt_bin_o = '0;
    gnt_vld_o = 1'b0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      idx = (int'(ptr_i) + i) % NUM_PORTS;
      if (!gnt_vld_o && req_i[idx]) begin
        gnt_vld_o     = 1'b1;
        gnt_oh_o[idx] = 1'b1;
        gnt_bin_o     = PTR_W'(idx);
      end else begin
        gnt_vld_o = gnt_vld_o;
      end
    end
  end

endmodule

// File: rtl/ddr_port_arbiter_chk.sv
// Simulation-only checks on the arbiter's latched request parameters.
module ddr_port_arbiter_chk
  import ddr_port_arbiter_pkg::*;
(
  input logic       clk_i,
  input logic       rst_i,
  input logic       grant_i,
  input logic [3:0] bw_i
);

  // A granted line length beyond 16 words cannot be expressed on local_size
  a_bw_range: assert property (@(posedge clk_i) disable iff (rst_i)
    grant_i |-> (bw_i <= 4'(MAX_BW)));

endmodule

// File: rtl/ddr_port_arbiter.sv
// Round-robins NUM_PORTS port requests onto one DDR Avalon-MM local port.
// Reads are line-fill bursts, writes single beats; accepted writes are
// echoed on bufw_* so every port's read buffer stays coherent.
module ddr_port_arbiter
  import ddr_port_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int LADR_W    = 24,
  parameter int SIZE_W    = 5
) (
  input  logic                   sdram_clk,
  input  logic                   sdram_rst,
  input  logic [NUM_PORTS-1:0]   port_acc_i,
  input  logic [NUM_PORTS-1:0]   port_we_i,
  input  logic [32*NUM_PORTS-1:0] port_adr_i,
  input  logic [32*NUM_PORTS-1:0] port_dat_i,
  input  logic [4*NUM_PORTS-1:0] port_sel_i,
  input  logic [4*NUM_PORTS-1:0] port_buf_width_i,
  output logic [NUM_PORTS-1:0]   port_ack_o,
  output logic [31:0]            port_adr_o,
  output logic [31:0]            port_dat_o,
  output logic                   bufw_we_o,
  output logic [31:0]            bufw_adr_o,
  output logic [31:0]            bufw_dat_o,
  output logic [3:0]             bufw_sel_o,
  input  logic                   local_init_done,
  input  logic                   local_ready,
  output logic                   local_read_req,
  output logic                   local_write_req,
  output logic                   local_burstbegin,
  output logic [LADR_W-1:0]      local_address,
  output logic [SIZE_W-1:0]      local_size,
  output logic [31:0]            local_wdata,
  output logic [3:0]             local_be,
  input  logic [31:0]            local_rdata,
  input  logic                   local_rdata_valid
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  state_e state_q, state_d;

  // Transaction latched at grant time
  logic [PTR_W-1:0]     grant_q, rr_q;
  logic [NUM_PORTS-1:0] gnt_oh_q;
  logic [31:0]          adr_q, dat_q;
  logic [3:0]           sel_q, bw_q;

  // Registered outputs and beat counter
  logic                 read_req_q, read_req_d, write_req_q, write_req_d;
  logic                 burstbegin_q, burstbegin_d, bufw_we_q, bufw_we_d;
  logic [LADR_W-1:0]    address_q, address_d;
  logic [SIZE_W-1:0]    size_q, size_d;
  logic [31:0]          wdata_q, wdata_d, port_adr_q, port_adr_d, port_dat_q, port_dat_d;
  logic [31:0]          bufw_adr_q, bufw_adr_d, bufw_dat_q, bufw_dat_d;
  logic [3:0]           be_q, be_d, bufw_sel_q, bufw_sel_d;
  logic [NUM_PORTS-1:0] ack_q, ack_d;
  logic [BEAT_W-1:0]    beat_q, beat_d;

  logic [NUM_PORTS-1:0] gnt_oh_s;
  logic [PTR_W-1:0]     gnt_bin_s;
  logic                 gnt_vld_s, grant_en_s, sel_we_s, last_beat_s;
  logic [31:0]          sel_adr_s, sel_dat_s, line_base_s;
  logic [3:0]           sel_sel_s, sel_bw_s;

  arb_rr #(.NUM_PORTS(NUM_PORTS), .PTR_W(PTR_W)) u_arb (
    .req_i     (port_acc_i),
    .ptr_i     (rr_q),
    .gnt_oh_o  (gnt_oh_s),
    .gnt_bin_o (gnt_bin_s),
    .gnt_vld_o (gnt_vld_s)
  );

  ddr_port_arbiter_chk u_chk (
    .clk_i   (sdram_clk),
    .rst_i   (sdram_rst),
    .grant_i (grant_en_s),
    .bw_i    (sel_bw_s)
  );

  assign sel_we_s    = port_we_i[gnt_bin_s];
  assign sel_adr_s   = port_adr_i[32*int'(gnt_bin_s) +: 32];
  assign sel_dat_s   = port_dat_i[32*int'(gnt_bin_s) +: 32];
  assign sel_sel_s   = port_sel_i[4*int'(gnt_bin_s) +: 4];
  assign sel_bw_s    = port_buf_width_i[4*int'(gnt_bin_s) +: 4];
  assign line_base_s = sel_adr_s & ~beat_mask(sel_bw_s);
  assign grant_en_s  = (state_q == ST_IDLE) && local_init_done && gnt_vld_s;
  assign last_beat_s = (beat_q == BEAT_W'((5'd1 << bw_q) - 5'd1));

  // State register
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_en_s) state_d = sel_we_s ? ST_WR_REQ : ST_RD_REQ;
        else            state_d = ST_IDLE;
      end
      ST_WR_REQ: begin
        if (local_ready) state_d = ST_DONE;
        else             state_d = ST_WR_REQ;
      end
      ST_RD_REQ: begin
        if (local_ready) state_d = ST_RD_DATA;
        else             state_d = ST_RD_REQ;
      end
      ST_RD_DATA: begin
        if (local_rdata_valid && last_beat_s) state_d = ST_DONE;
        else                                  state_d = ST_RD_DATA;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values; strobes default low, payloads hold
  always_comb begin
    read_req_d   = 1'b0;
    write_req_d  = 1'b0;
    burstbegin_d = 1'b0;
    bufw_we_d    = 1'b0;
    ack_d        = '0;
    address_d    = address_q;
    size_d       = size_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    port_adr_d   = port_adr_q;
    port_dat_d   = port_dat_q;
    bufw_adr_d   = bufw_adr_q;
    bufw_dat_d   = bufw_dat_q;
    bufw_sel_d   = bufw_sel_q;
    beat_d       = beat_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_en_s) begin
          burstbegin_d = 1'b1;
          beat_d       = '0;
          if (sel_we_s) begin
            write_req_d = 1'b1;
            address_d   = sel_adr_s[LADR_W+1:2];
            size_d      = SIZE_W'(1);
            wdata_d     = sel_dat_s;
            be_d        = sel_sel_s;
          end else begin
            read_req_d = 1'b1;
            address_d  = line_base_s[LADR_W+1:2];
            size_d     = SIZE_W'(1) << sel_bw_s;
          end
        end else begin
          beat_d = beat_q;
        end
      end
      ST_WR_REQ: begin
        if (local_ready) begin
          ack_d      = gnt_oh_q;
          port_adr_d = adr_q;
          bufw_we_d  = 1'b1;
          bufw_adr_d = adr_q;
          bufw_dat_d = dat_q;
          bufw_sel_d = sel_q;
        end else begin
          write_req_d = 1'b1;
        end
      end
      ST_RD_REQ: begin
        if (local_ready) read_req_d = 1'b0;
        else             read_req_d = 1'b1;
      end
      ST_RD_DATA: begin
        if (local_rdata_valid) begin
          ack_d      = gnt_oh_q;
          port_dat_d = local_rdata;
          port_adr_d = (adr_q & ~beat_mask(bw_q)) | ({28'd0, beat_q} << 2);
          beat_d     = beat_q + BEAT_W'(1);
        end else begin
          beat_d = beat_q;
        end
      end
      ST_DONE: beat_d = beat_q;
      default: beat_d = beat_q;
    endcase
  end

  // Output registers and beat counter
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      read_req_q   <= 1'b0;
      write_req_q  <= 1'b0;
      burstbegin_q <= 1'b0;
      bufw_we_q    <= 1'b0;
      ack_q        <= '0;
      address_q    <= '0;
      size_q       <= '0;
      wdata_q      <= 32'd0;
      be_q         <= 4'd0;
      port_adr_q   <= 32'd0;
      port_dat_q   <= 32'd0;
      bufw_adr_q   <= 32'd0;
      bufw_dat_q   <= 32'd0;
      bufw_sel_q   <= 4'd0;
      beat_q       <= '0;
    end else begin
      read_req_q   <= read_req_d;
      write_req_q  <= write_req_d;
      burstbegin_q <= burstbegin_d;
      bufw_we_q    <= bufw_we_d;
      ack_q        <= ack_d;
      address_q    <= address_d;
      size_q       <= size_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      port_adr_q   <= port_adr_d;
      port_dat_q   <= port_dat_d;
      bufw_adr_q   <= bufw_adr_d;
      bufw_dat_q   <= bufw_dat_d;
      bufw_sel_q   <= bufw_sel_d;
      beat_q       <= beat_d;
    end
  end

  // Latch the granted request and advance the round-robin pointer on completion
  always_ff @(posedge sdram_clk) begin
    if (sdram_rst) begin
      grant_q  <= '0;
      gnt_oh_q <= '0;
      adr_q    <= 32'd0;
      dat_q    <= 32'd0;
      sel_q    <= 4'd0;
      bw_q     <= 4'd0;
      rr_q     <= '0;
    end else if (grant_en_s) begin
      grant_q  <= gnt_bin_s;
      gnt_oh_q <= gnt_oh_s;
      adr_q    <= sel_adr_s;
      dat_q    <= sel_dat_s;
      sel_q    <= sel_sel_s;
      bw_q     <= sel_bw_s;
    end else if (state_q == ST_DONE) begin
      rr_q <= grant_q;
    end else begin
      rr_q <= rr_q;
    end
  end

  assign port_ack_o       = ack_q;
  assign port_adr_o       = port_adr_q;
  assign port_dat_o       = port_dat_q;
  assign bufw_we_o        = bufw_we_q;
  assign bufw_adr_o       = bufw_adr_q;
  assign bufw_dat_o       = bufw_dat_q;
  assign bufw_sel_o       = bufw_sel_q;
  assign local_read_req   = read_req_q;
  assign local_write_req  = write_req_q;
  assign local_burstbegin = burstbegin_q;
  assign local_address    = address_q;
  assign local_size       = size_q;
  assign local_wdata      = wdata_q;
  assign local_be         = be_q;

endmodule
